inverse_check_2x2: RTL

//   Sequential checker/consumer for 2x2 inverse results. Accepts matrix A and a

---
 rtl/inverse_check_2x2.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/inverse_check_2x2.sv
// Sequential self-check for 2x2 adjugate results: C = A*B and det(A) on one shared
// signed multiplier, then flags whether B is the true adjugate of A.
`timescale 1ns/1ps
module inverse_check_2x2 #(
    parameter  int W  = 4,
    localparam int CW = 2*W+1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  a11,
    input  logic signed [W-1:0]  a12,
    input  logic signed [W-1:0]  a21,
    input  logic signed [W-1:0]  a22,
    input  logic signed [W-1:0]  b11,
    input  logic signed [W-1:0]  b12,
    input  logic signed [W-1:0]  b21,
    input  logic signed [W-1:0]  b22,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [CW-1:0] c11,
    output logic signed [CW-1:0] c12,
    output logic signed [CW-1:0] c21,
    output logic signed [CW-1:0] c22,
    output logic signed [CW-1:0] det,
    output logic                 is_adj,
    output logic                 singular
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t r_state, w_stateNext;

    logic signed [W-1:0]    r_a11, r_a12, r_a21, r_a22;
    logic signed [W-1:0]    r_b11, r_b12, r_b21, r_b22;
    logic [3:0]             r_step;
    logic signed [CW-1:0]   r_acc;
    logic signed [CW-1:0]   r_w11, r_w12, r_w21, r_w22;
    logic signed [CW-1:0]   r_c11, r_c12, r_c21, r_c22, r_det;
    logic                   r_isAdj, r_singular;

    logic signed [W-1:0]    w_opX, w_opY;
    logic signed [2*W-1:0]  w_prod;
    logic signed [CW-1:0]   w_prodExt;
    logic signed [CW-1:0]   w_sum;
    logic                   w_singular, w_isAdj;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (in_valid)          w_stateNext = MUL;
            MUL:     if (r_step == 4'd9)    w_stateNext = DONE;
            DONE:    if (out_ready)         w_stateNext = IDLE;
            default:                        w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Operand schedule: pairs of products per C entry, then the two det terms.
    always_comb begin
        w_opX = '0;
        w_opY = '0;
        case (r_step)
            4'd0: begin w_opX = r_a11; w_opY = r_b11; end
            4'd1: begin w_opX = r_a12; w_opY = r_b21; end
            4'd2: begin w_opX = r_a11; w_opY = r_b12; end
            4'd3: begin w_opX = r_a12; w_opY = r_b22; end
            4'd4: begin w_opX = r_a21; w_opY = r_b11; end
            4'd5: begin w_opX = r_a22; w_opY = r_b21; end
            4'd6: begin w_opX = r_a21; w_opY = r_b12; end
            4'd7: begin w_opX = r_a22; w_opY = r_b22; end
            4'd8: begin w_opX = r_a11; w_opY = r_a22; end
            4'd9: begin w_opX = r_a12; w_opY = r_a21; end
            default: begin w_opX = '0; w_opY = '0; end
        endcase
    end

    assign w_prod    = (2*W)'(w_opX) * (2*W)'(w_opY);
    assign w_prodExt = CW'(w_prod);
    assign w_sum     = (r_step == 4'd9) ? (r_acc - w_prodExt) : (r_acc + w_prodExt);

    // Flags use the finished C entries and the det being written this cycle.
    assign w_singular = (w_sum == '0);
    assign w_isAdj    = !w_singular && (r_w12 == '0) && (r_w21 == '0)
                        && (r_w11 == w_sum) && (r_w22 == w_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a11 <= '0; r_a12 <= '0; r_a21 <= '0; r_a22 <= '0;
            r_b11 <= '0; r_b12 <= '0; r_b21 <= '0; r_b22 <= '0;
            r_step     <= '0;
            r_acc      <= '0;
            r_w11      <= '0; r_w12 <= '0; r_w21 <= '0; r_w22 <= '0;
            r_c11      <= '0; r_c12 <= '0; r_c21 <= '0; r_c22 <= '0;
            r_det      <= '0;
            r_isAdj    <= 1'b0;
            r_singular <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a11 <= a11; r_a12 <= a12; r_a21 <= a21; r_a22 <= a22;
                        r_b11 <= b11; r_b12 <= b12; r_b21 <= b21; r_b22 <= b22;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                MUL: begin
                    if (!r_step[0]) begin
                        r_acc <= w_prodExt;
                    end else begin
                        case (r_step)
                            4'd1: r_w11 <= w_sum;
                            4'd3: r_w12 <= w_sum;
                            4'd5: r_w21 <= w_sum;
                            4'd7: r_w22 <= w_sum;
                            4'd9: begin
                                r_c11      <= r_w11;
                                r_c12      <= r_w12;
                                r_c21      <= r_w21;
                                r_c22      <= r_w22;
                                r_det      <= w_sum;
                                r_isAdj    <= w_isAdj;
                                r_singular <= w_singular;
                            end
                            default: ;
                        endcase
                    end
                    r_step <= (r_step == 4'd9) ? 4'd0 : r_step + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign c11      = r_c11;
    assign c12      = r_c12;
    assign c21      = r_c21;
    assign c22      = r_c22;
    assign det      = r_det;
    assign is_adj   = r_isAdj;
    assign singular = r_singular;

endmodule
